// File: rtl/mem_bank_arbiter_pkg.sv
// Shared types and constants for the SRAM bank arbiter slice.
// The 12-bit word address splits into a 2-bit bank select (top bits)
// and a 10-bit row address for the 8x1024 macro pairs.
package mem_arb_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int BANK_W    = 2;
    localparam int ROW_W     = 10;
    localparam int NUM_BANKS = 1 << BANK_W;

    // Which requester owns an access travelling down the pipeline
    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_WB  = 1'b1
    } src_e;

    // Tag that follows each granted access from S1 to S2 so the
    // returning read data can be steered to its owner
    typedef struct packed {
        logic                valid;
        src_e                src;
        logic [BANK_W-1:0]   bank;
        logic                is_read;
    } pipe_tag_t;

    // Bank number taken from the top of the word address
    function automatic logic [BANK_W-1:0] addrBank(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: BANK_W];
    endfunction

    // Row address inside a bank
    function automatic logic [ROW_W-1:0] addrRow(input logic [ADDR_W-1:0] addr);
        return addr[ROW_W-1:0];
    endfunction

    // Active-low one-hot chip select for a bank
    function automatic logic [NUM_BANKS-1:0] bankSelectN(input logic [BANK_W-1:0] bank);
        logic [NUM_BANKS-1:0] oneHot;
        oneHot       = '0;
        oneHot[bank] = 1'b1;
        return ~oneHot;
    endfunction

endpackage

// File: rtl/mem_bank_arbiter_if.sv
// Bundle of the CPU port, the loader (Wishbone-style) port and the
// SRAM macro side of the arbiter. The arbiter uses the slave view;
// the master view is the environment driving requests and modelling
// the macros.
interface mem_bank_arbiter_if;
    import mem_arb_pkg::*;

    // CPU port
    logic                 cpu_en;
    logic                 cpu_rw;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [DATA_W-1:0]    cpu_wdata;
    logic                 cpu_stall;
    logic                 cpu_rvalid;
    logic [DATA_W-1:0]    cpu_rdata;

    // Loader port
    logic                 wb_req;
    logic                 wb_we;
    logic [ADDR_W-1:0]    wb_addr;
    logic [DATA_W-1:0]    wb_wdata;
    logic                 wb_ack;
    logic [DATA_W-1:0]    wb_rdata;

    // SRAM macro side
    logic [NUM_BANKS-1:0] mem_csb;
    logic                 mem_web;
    logic [ROW_W-1:0]     mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata0;
    logic [DATA_W-1:0]    mem_rdata1;
    logic [DATA_W-1:0]    mem_rdata2;
    logic [DATA_W-1:0]    mem_rdata3;

    modport slave (
        input  cpu_en, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  wb_req, wb_we, wb_addr, wb_wdata,
        output wb_ack, wb_rdata,
        output mem_csb, mem_web, mem_addr, mem_wdata,
        input  mem_rdata0, mem_rdata1, mem_rdata2, mem_rdata3
    );

    modport master (
        output cpu_en, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output wb_req, wb_we, wb_addr, wb_wdata,
        input  wb_ack, wb_rdata,
        input  mem_csb, mem_web, mem_addr, mem_wdata,
        output mem_rdata0, mem_rdata1, mem_rdata2, mem_rdata3
    );

endinterface

// File: rtl/mem_bank_arbiter_rdmux.sv
// Completion stage of the arbiter: picks the read data of the bank
// named by the S2 tag, registers it into the owner's read-data
// register and raises that owner's one-cycle completion pulse.
// Writes pulse the completion flag without touching read data, and
// both read-data registers hold between pulses.
module mem_bank_rdmux
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  pipe_tag_t         i_tag,
    input  logic [DATA_W-1:0] i_memRdata0,
    input  logic [DATA_W-1:0] i_memRdata1,
    input  logic [DATA_W-1:0] i_memRdata2,
    input  logic [DATA_W-1:0] i_memRdata3,
    output logic              o_cpuRvalid,
    output logic [DATA_W-1:0] o_cpuRdata,
    output logic              o_wbAck,
    output logic [DATA_W-1:0] o_wbRdata
);

    logic [DATA_W-1:0] w_bankData;
    logic              r_cpuRvalid;
    logic [DATA_W-1:0] r_cpuRdata;
    logic              r_wbAck;
    logic [DATA_W-1:0] r_wbRdata;

    // 4:1 selection of the macro output addressed by the S2 tag
    always_comb begin
        w_bankData = i_memRdata0;
        case (i_tag.bank)
            2'd0:    w_bankData = i_memRdata0;
            2'd1:    w_bankData = i_memRdata1;
            2'd2:    w_bankData = i_memRdata2;
            default: w_bankData = i_memRdata3;
        endcase
    end

    // Register the completion pulse and steer read data to its owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpuRvalid <= 1'b0;
            r_cpuRdata  <= '0;
            r_wbAck     <= 1'b0;
            r_wbRdata   <= '0;
        end else begin
            r_cpuRvalid <= i_tag.valid && (i_tag.src == SRC_CPU);
            r_wbAck     <= i_tag.valid && (i_tag.src == SRC_WB);
            if (i_tag.valid && i_tag.is_read) begin
                if (i_tag.src == SRC_CPU) begin
                    r_cpuRdata <= w_bankData;
                end else begin
                    r_wbRdata  <= w_bankData;
                end
            end
        end
    end

    assign o_cpuRvalid = r_cpuRvalid;
    assign o_cpuRdata  = r_cpuRdata;
    assign o_wbAck     = r_wbAck;
    assign o_wbRdata   = r_wbRdata;

endmodule

// File: rtl/mem_bank_arbiter.sv
// Arbiter between the CPU port and the management-side loader for the
// four 16-bit SRAM word banks. One access is granted per cycle, driven
// onto the macro pins at the grant edge (S1), tagged through the macro
// capture edge (S2) and completed one edge later by the read mux, so a
// requester sees its rvalid/ack three edges after its grant.
// The CPU normally wins; the loader wins when the CPU is idle or after
// it has lost WB_MAX_WAIT times in a row. The loader may have only one
// access outstanding and is held off through its own ack cycle so a
// still-high wb_req cannot issue the same transfer twice.
module mem_bank_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WB_MAX_WAIT = 4
)(
    input  logic clk,
    input  logic rst,
    mem_bank_arbiter_if.slave bus
);

    localparam logic [3:0] WAIT_LIMIT = 4'(WB_MAX_WAIT);

    logic                 w_wbInFlight;
    logic                 w_wbEligible;
    logic                 w_wbGrant;
    logic                 w_cpuGrant;
    logic                 w_anyGrant;
    logic [ADDR_W-1:0]    w_reqAddr;
    logic [DATA_W-1:0]    w_reqWdata;
    logic                 w_reqWrite;
    pipe_tag_t            w_s1Next;

    logic [3:0]           r_wbWait;
    logic [NUM_BANKS-1:0] r_memCsb;
    logic                 r_memWeb;
    logic [ROW_W-1:0]     r_memAddr;
    logic [DATA_W-1:0]    r_memWdata;
    pipe_tag_t            r_s1Tag;
    pipe_tag_t            r_s2Tag;

    logic                 w_cpuRvalid;
    logic [DATA_W-1:0]    w_cpuRdata;
    logic                 w_wbAck;
    logic [DATA_W-1:0]    w_wbRdata;

    // Loader access is outstanding from its grant until its ack cycle ends
    always_comb begin
        w_wbInFlight = (r_s1Tag.valid && (r_s1Tag.src == SRC_WB)) ||
                       (r_s2Tag.valid && (r_s2Tag.src == SRC_WB)) ||
                       w_wbAck;
        w_wbEligible = bus.wb_req && !w_wbInFlight;
        w_wbGrant    = w_wbEligible && (!bus.cpu_en || (r_wbWait == WAIT_LIMIT));
        w_cpuGrant   = bus.cpu_en && !w_wbGrant;
        w_anyGrant   = w_cpuGrant || w_wbGrant;
    end

    // Select the winning request and build the tag it will carry
    always_comb begin
        w_reqAddr  = bus.cpu_addr;
        w_reqWdata = bus.cpu_wdata;
        w_reqWrite = bus.cpu_rw;
        if (w_wbGrant) begin
            w_reqAddr  = bus.wb_addr;
            w_reqWdata = bus.wb_wdata;
            w_reqWrite = bus.wb_we;
        end
        w_s1Next         = '0;
        w_s1Next.valid   = w_anyGrant;
        w_s1Next.src     = w_wbGrant ? SRC_WB : SRC_CPU;
        w_s1Next.bank    = addrBank(w_reqAddr);
        w_s1Next.is_read = !w_reqWrite;
    end

    // Count consecutive losses of an eligible loader, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbWait <= '0;
        end else if (!bus.wb_req || w_wbGrant) begin
            r_wbWait <= '0;
        end else if (w_wbEligible && (r_wbWait != WAIT_LIMIT)) begin
            r_wbWait <= r_wbWait + 4'd1;
        end
    end

    // S1: drive the granted access onto the macro pins; idle cycles only deselect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memCsb   <= '1;
            r_memWeb   <= 1'b1;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_s1Tag    <= '0;
        end else begin
            r_s1Tag <= w_s1Next;
            if (w_anyGrant) begin
                r_memCsb   <= bankSelectN(addrBank(w_reqAddr));
                r_memWeb   <= !w_reqWrite;
                r_memAddr  <= addrRow(w_reqAddr);
                r_memWdata <= w_reqWdata;
            end else begin
                r_memCsb   <= '1;
            end
        end
    end

    // S2: follow the macros' capture edge so the tag lines up with their output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Tag <= '0;
        end else begin
            r_s2Tag <= r_s1Tag;
        end
    end

    mem_bank_rdmux u_rdmux (
        .clk         (clk),
        .rst         (rst),
        .i_tag       (r_s2Tag),
        .i_memRdata0 (bus.mem_rdata0),
        .i_memRdata1 (bus.mem_rdata1),
        .i_memRdata2 (bus.mem_rdata2),
        .i_memRdata3 (bus.mem_rdata3),
        .o_cpuRvalid (w_cpuRvalid),
        .o_cpuRdata  (w_cpuRdata),
        .o_wbAck     (w_wbAck),
        .o_wbRdata   (w_wbRdata)
    );

    assign bus.cpu_stall  = bus.cpu_en && !w_cpuGrant;
    assign bus.cpu_rvalid = w_cpuRvalid;
    assign bus.cpu_rdata  = w_cpuRdata;
    assign bus.wb_ack     = w_wbAck;
    assign bus.wb_rdata   = w_wbRdata;
    assign bus.mem_csb    = r_memCsb;
    assign bus.mem_web    = r_memWeb;
    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_wdata  = r_memWdata;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Self-checking bench for mem_bank_arbiter: a behavioural SRAM model
// on the macro pins, a transaction-level reference (flat 4096-word
// memory plus a schedule of expected completions), directed scenarios
// and a randomized traffic phase.
module tb_mem_bank_arbiter;
    import mem_arb_pkg::*;

    localparam int WB_MAX_WAIT = 4;
    localparam int SLOTS       = 4096;

    logic clk;
    logic rst;
    mem_bank_arbiter_if bus ();

    mem_bank_arbiter #(.WB_MAX_WAIT(WB_MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM macros: capture on clk, read data valid after the edge
    logic [15:0] sramArr  [4][1024];
    logic [15:0] sramDout [4];
    logic        memClear;

    always @(posedge clk) begin
        if (memClear) begin
            for (int b = 0; b < 4; b++) begin
                sramDout[b] <= '0;
                for (int r = 0; r < 1024; r++) sramArr[b][r] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.mem_csb[b]) begin
                    if (!bus.mem_web) sramArr[b][bus.mem_addr] <= bus.mem_wdata;
                    else              sramDout[b] <= sramArr[b][bus.mem_addr];
                end
            end
        end
    end

    assign bus.mem_rdata0 = sramDout[0];
    assign bus.mem_rdata1 = sramDout[1];
    assign bus.mem_rdata2 = sramDout[2];
    assign bus.mem_rdata3 = sramDout[3];

    // Reference state
    int          testsRun;
    int          testsFailed;
    int          cyc;
    logic [15:0] refMem   [SLOTS];
    bit          expCpuV  [SLOTS];
    bit          expCpuRd [SLOTS];
    logic [15:0] expCpuD  [SLOTS];
    bit          expWbV   [SLOTS];
    bit          expWbRd  [SLOTS];
    logic [15:0] expWbD   [SLOTS];
    logic [3:0]  expCsb   [SLOTS];
    logic [9:0]  expAddr  [SLOTS];
    logic        expWeb   [SLOTS];
    logic [15:0] expWdata [SLOTS];
    logic [15:0] lastCpuD;
    logic [15:0] lastWbD;
    int          wbWait;
    int          wbBusyUntil;
    bit          cpuHold;

    // Stimulus holders
    logic        cEn, cRw, wReq, wWe;
    logic [11:0] cAddr, wAddr;
    logic [15:0] cData, wData;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rw, input logic [11:0] ca,
                                 input logic [15:0] cd, input logic req, input logic we,
                                 input logic [11:0] wa, input logic [15:0] wd);
        bus.cpu_en    = en;
        bus.cpu_rw    = rw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.wb_req    = req;
        bus.wb_we     = we;
        bus.wb_addr   = wa;
        bus.wb_wdata  = wd;
        #1;
    endtask

    // Record what a grant in the current cycle must produce later
    task automatic recordGrant(input bit isWb, input logic write,
                               input logic [11:0] addr, input logic [15:0] data);
        logic [15:0] rd;
        expCsb[cyc+1]   = ~(4'b0001 << addr[11:10]);
        expAddr[cyc+1]  = addr[9:0];
        expWeb[cyc+1]   = ~write;
        expWdata[cyc+1] = data;
        rd = refMem[addr];
        if (write) refMem[addr] = data;
        if (isWb) begin
            expWbV[cyc+3]  = 1'b1;
            expWbRd[cyc+3] = !write;
            expWbD[cyc+3]  = rd;
            wbBusyUntil    = cyc + 3;
        end else begin
            expCpuV[cyc+3]  = 1'b1;
            expCpuRd[cyc+3] = !write;
            expCpuD[cyc+3]  = rd;
        end
    endtask

    task automatic resetModel();
        for (int i = cyc; i < SLOTS; i++) begin
            expCpuV[i] = 1'b0;
            expWbV[i]  = 1'b0;
            expCsb[i]  = 4'hF;
        end
        lastCpuD    = '0;
        lastWbD     = '0;
        wbWait      = 0;
        wbBusyUntil = -1;
        cpuHold     = 1'b0;
    endtask

    // One clock cycle: check outputs against the reference, arbitrate, advance
    task automatic stepCycle();
        bit wbElig, wbGnt, cpuGnt;
        @(negedge clk);
        if (expCpuV[cyc] && expCpuRd[cyc]) lastCpuD = expCpuD[cyc];
        if (expWbV[cyc] && expWbRd[cyc])   lastWbD  = expWbD[cyc];
        checkOutput("cpu_rvalid", bus.cpu_rvalid, expCpuV[cyc]);
        checkOutput("cpu_rdata",  bus.cpu_rdata,  lastCpuD);
        checkOutput("wb_ack",     bus.wb_ack,     expWbV[cyc]);
        checkOutput("wb_rdata",   bus.wb_rdata,   lastWbD);
        checkOutput("mem_csb",    bus.mem_csb,    expCsb[cyc]);
        if (expCsb[cyc] != 4'hF) begin
            checkOutput("mem_addr",  bus.mem_addr,  expAddr[cyc]);
            checkOutput("mem_web",   bus.mem_web,   expWeb[cyc]);
            checkOutput("mem_wdata", bus.mem_wdata, expWdata[cyc]);
        end
        wbElig = bus.wb_req && (cyc > wbBusyUntil);
        wbGnt  = wbElig && (!bus.cpu_en || wbWait == WB_MAX_WAIT);
        cpuGnt = bus.cpu_en && !wbGnt;
        checkOutput("cpu_stall", bus.cpu_stall, bus.cpu_en && !cpuGnt);
        if (cpuGnt)     recordGrant(1'b0, bus.cpu_rw, bus.cpu_addr, bus.cpu_wdata);
        else if (wbGnt) recordGrant(1'b1, bus.wb_we, bus.wb_addr, bus.wb_wdata);
        if (!bus.wb_req || wbGnt)                 wbWait = 0;
        else if (wbElig && wbWait < WB_MAX_WAIT)  wbWait++;
        cpuHold = bus.cpu_en && !cpuGnt;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [11:0] randAddr();
        if ($urandom_range(0, 7) == 0) return 12'hFFF;
        return {2'($urandom_range(0, 3)), 6'b0, 4'($urandom_range(0, 15))};
    endfunction

    int stalls, stallAt, ackAt, pulses;

    initial begin
        testsRun = 0; testsFailed = 0; cyc = 0;
        for (int i = 0; i < SLOTS; i++) begin
            refMem[i] = '0; expCpuV[i] = 0; expWbV[i] = 0; expCsb[i] = 4'hF;
            expCpuRd[i] = 0; expWbRd[i] = 0; expCpuD[i] = '0; expWbD[i] = '0;
            expAddr[i] = '0; expWeb[i] = 1'b1; expWdata[i] = '0;
        end
        resetModel();
        memClear = 1'b1;
        rst = 1'b1;
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        memClear = 1'b0;
        checkOutput("rst_csb",    bus.mem_csb,    4'hF);
        checkOutput("rst_web",    bus.mem_web,    1'b1);
        checkOutput("rst_addr",   bus.mem_addr,   10'h0);
        checkOutput("rst_wdata",  bus.mem_wdata,  16'h0);
        checkOutput("rst_rvalid", bus.cpu_rvalid, 1'b0);
        checkOutput("rst_ack",    bus.wb_ack,     1'b0);
        rst = 1'b0;
        stepCycle();

        // CPU write then read of 0x805
        applyStimulus(1, 1, 12'h805, 16'hBEEF, 0, 0, 12'h0, 16'h0);
        stepCycle();
        checkOutput("wr805_csb",  bus.mem_csb,  4'b1011);
        checkOutput("wr805_addr", bus.mem_addr, 10'h005);
        applyStimulus(1, 0, 12'h805, 16'h0, 0, 0, 12'h0, 16'h0);
        stepCycle();
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
        stepCycle();
        stepCycle();
        checkOutput("rd805_rvalid", bus.cpu_rvalid, 1'b1);
        checkOutput("rd805_data",   bus.cpu_rdata,  16'hBEEF);

        // Preload 1,2,3 through the CPU, then back-to-back reads across banks
        applyStimulus(1, 1, 12'h001, 16'd1, 0, 0, 12'h0, 16'h0); stepCycle();
        applyStimulus(1, 1, 12'h401, 16'd2, 0, 0, 12'h0, 16'h0); stepCycle();
        applyStimulus(1, 1, 12'hC01, 16'd3, 0, 0, 12'h0, 16'h0); stepCycle();
        applyStimulus(1, 0, 12'h001, 16'h0, 0, 0, 12'h0, 16'h0);
        checkOutput("b2b_stall0", bus.cpu_stall, 1'b0); stepCycle();
        applyStimulus(1, 0, 12'h401, 16'h0, 0, 0, 12'h0, 16'h0);
        checkOutput("b2b_stall1", bus.cpu_stall, 1'b0); stepCycle();
        applyStimulus(1, 0, 12'hC01, 16'h0, 0, 0, 12'h0, 16'h0);
        checkOutput("b2b_stall2", bus.cpu_stall, 1'b0); stepCycle();
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
        checkOutput("b2b_data0", bus.cpu_rdata, 16'd1); stepCycle();
        checkOutput("b2b_data1", bus.cpu_rdata, 16'd2); stepCycle();
        checkOutput("b2b_data2", bus.cpu_rdata, 16'd3);
        checkOutput("b2b_valid2", bus.cpu_rvalid, 1'b1); stepCycle();

        // Loader write to 0x3FF with the CPU idle, then CPU reads it back
        applyStimulus(0, 0, 12'h0, 16'h0, 1, 1, 12'h3FF, 16'h1234);
        stepCycle(); stepCycle(); stepCycle();
        checkOutput("ldw_ack", bus.wb_ack, 1'b1);
        applyStimulus(1, 0, 12'h3FF, 16'h0, 0, 0, 12'h0, 16'h0);
        stepCycle();
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
        stepCycle(); stepCycle();
        checkOutput("ldw_readback", bus.cpu_rdata, 16'h1234);

        // Starvation bound: CPU busy every cycle while the loader waits
        stalls = 0; stallAt = -1; ackAt = -1; wReq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.wb_ack) begin ackAt = i; wReq = 1'b0; end
            applyStimulus(1, 0, 12'h123, 16'h0, wReq, 0, 12'h456, 16'h0);
            if (bus.cpu_stall) begin stalls++; stallAt = i; end
            stepCycle();
        end
        checkOutput("starve_stalls",  stalls,  1);
        checkOutput("starve_stallAt", stallAt, 4);
        checkOutput("starve_ackAt",   ackAt,   7);

        // Adjacent CPU read of bank 0 and loader read of bank 2: no crossover
        applyStimulus(1, 1, 12'h010, 16'hA5A5, 0, 0, 12'h0, 16'h0); stepCycle();
        applyStimulus(1, 1, 12'h810, 16'h5A5A, 0, 0, 12'h0, 16'h0); stepCycle();
        applyStimulus(1, 0, 12'h010, 16'h0, 1, 0, 12'h810, 16'h0); stepCycle();
        applyStimulus(0, 0, 12'h0, 16'h0, 1, 0, 12'h810, 16'h0); stepCycle();
        stepCycle();
        checkOutput("mix_cpu_valid", bus.cpu_rvalid, 1'b1);
        checkOutput("mix_cpu_data",  bus.cpu_rdata,  16'hA5A5);
        stepCycle();
        checkOutput("mix_wb_ack",    bus.wb_ack,     1'b1);
        checkOutput("mix_wb_data",   bus.wb_rdata,   16'h5A5A);
        checkOutput("mix_cpu_hold",  bus.cpu_rdata,  16'hA5A5);
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0); stepCycle();

        // Reset one cycle after a CPU read grant: everything dropped
        applyStimulus(1, 0, 12'h001, 16'h0, 0, 0, 12'h0, 16'h0);
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_csb",    bus.mem_csb,    4'hF);
        checkOutput("mid_rst_web",    bus.mem_web,    1'b1);
        checkOutput("mid_rst_addr",   bus.mem_addr,   10'h0);
        checkOutput("mid_rst_wdata",  bus.mem_wdata,  16'h0);
        checkOutput("mid_rst_rdata",  bus.cpu_rdata,  16'h0);
        checkOutput("mid_rst_wbdata", bus.wb_rdata,   16'h0);
        resetModel();
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
        stepCycle(); stepCycle();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.cpu_rvalid) pulses++;
            stepCycle();
        end
        checkOutput("mid_rst_no_rvalid", pulses, 0);

        // Randomized mixed traffic
        cEn = 0; cRw = 0; cAddr = '0; cData = '0;
        wReq = 0; wWe = 0; wAddr = '0; wData = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!cpuHold) begin
                cEn   = ($urandom_range(0, 99) < 60);
                cRw   = 1'($urandom_range(0, 1));
                cAddr = randAddr();
                cData = 16'($urandom);
            end
            if (wReq && cyc == wbBusyUntil) begin
                wReq = 1'b0;
            end else if (!wReq && $urandom_range(0, 2) == 0) begin
                wReq  = 1'b1;
                wWe   = 1'($urandom_range(0, 1));
                wAddr = randAddr();
                wData = 16'($urandom);
            end
            applyStimulus(cEn, cRw, cAddr, cData, wReq, wWe, wAddr, wData);
            stepCycle();
        end
        applyStimulus(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0);
        repeat (4) stepCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_bank_arbiter.md
Name: mem_bank_arbiter

Overview:
- Sits between the CPU/SoC glue and the four 16-bit SRAM word banks. Each bank is a pair of 8x1024 macros.
- Arbitrates between the CPU port and a management-side loader port.
  - The loader port carries Wishbone accesses already decoded by soc_config.
- Decodes the 12-bit word address into a one-hot bank chip-select and a 10-bit row address.
- Pipelines accesses around the macros' synchronous latency, then steers returned read data to the correct requester.

Parameters:
- ADDR_W, 12, requester word-address width; upper 2 bits select the bank.
- DATA_W, 16, word width.
- WB_MAX_WAIT, 4, cycles a pending loader request may lose arbitration before it is forced to win (range 1..15).

Ports:
- clk  in  1  SoC clock; also drives the macros' clk0.
- rst  in  1  asynchronous, active-high reset.
- cpu_en  in  1  CPU access request.
- cpu_rw  in  1  1 = write, 0 = read.
- cpu_addr  in  12  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_stall  out  1  combinational; CPU must hold its request while high.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid / write completed.
- cpu_rdata  out  16  read data to the CPU.
- wb_req  in  1  loader request; held high until wb_ack.
- wb_we  in  1  1 = write.
- wb_addr  in  12  loader word address.
- wb_wdata  in  16  loader write data.
- wb_ack  out  1  one-cycle completion pulse.
- wb_rdata  out  16  read data to the loader.
- mem_csb  out  4  active-low bank chip-selects (one-hot low).
- mem_web  out  1  active-low write enable.
- mem_addr  out  10  row address.
- mem_wdata  out  16  write data.
- mem_rdata0..mem_rdata3  in  16 each  bank read data.

Behaviour:
- Reset (async, immediate):
  - mem_csb=4'hF, mem_web=1, mem_addr=0, mem_wdata=0.
  - cpu_rvalid=0, wb_ack=0, cpu_rdata=0, wb_rdata=0.
  - Pipeline valids and wait counter cleared.
  - Reset mid-operation: in-flight accesses are dropped, and no rvalid/ack is produced for them.
- Arbitration at each clock edge, one grant per cycle. Loader is "eligible" when wb_req=1 and no loader access is in flight.
  - Default: the CPU wins whenever cpu_en=1.
  - The loader wins if it is eligible and cpu_en=0.
  - The loader also wins if it is eligible and wb_wait==WB_MAX_WAIT.
- cpu_stall = cpu_en & ~cpu_grant (combinational).
- wb_wait:
  - Increments (saturating) each cycle the loader is eligible but not granted.
  - Clears on loader grant or when wb_req=0.
- Stage S1 (edge E0), the granted request is registered onto the mem_* ports:
  - mem_csb = ~(4'b0001 << addr[11:10]).
  - mem_addr = addr[9:0].
  - mem_web = ~rw.
  - mem_wdata = wdata.
- With no grant: mem_csb=4'hF and the remaining mem_* outputs hold their values.
- Stage S2 (edge E1): the macros capture. A tag {valid, source, bank, is_read} moves S1→S2.
- Completion (edge E2):
  - Read: mem_rdata[bank] is registered into cpu_rdata or wb_rdata, selected by the S2 tag.
  - Read and write both pulse cpu_rvalid or wb_ack for exactly one cycle.
  - Latency is 3 edges from grant to the rvalid/ack cycle.
- CPU throughput: back-to-back CPU grants are allowed, one per cycle, fully pipelined.
- Loader is limited to one outstanding access.
  - wb_req must stay high until wb_ack.
  - Once acked, the loader is ineligible for the cycle in which wb_ack=1, which prevents a double issue.
- Read-after-write to the same address in consecutive grants returns the new data; no forwarding is needed because the macro orders it.
- cpu_rdata/wb_rdata hold their last value between pulses.
- Address wrap: 12'hFFF maps to bank 3 row 1023. There are no out-of-range addresses.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_W, DATA_W, BANK_W=2, ROW_W=10.
  - SRC_CPU/SRC_WB encodings.
  - Pipeline tag struct {valid, src, bank, is_read}.
- One natural sub-module: mem_bank_rdmux. It is the registered 4:1 read-data mux plus destination steering driven by the S2 tag.

Test Plan:
- Reset mid-read: assert rst one cycle after a CPU read grant → all outputs at reset values, and no cpu_rvalid pulse follows.
- CPU write 12'h805←16'hBEEF, then read 12'h805 → mem_csb=4'b1011, mem_addr=10'h005; cpu_rvalid 3 edges after the read grant with cpu_rdata=16'hBEEF.
- Back-to-back CPU reads to 12'h001, 12'h401, 12'hC01 (preloaded 1,2,3) → three consecutive cpu_rvalid pulses returning 1, 2, 3 in order; cpu_stall=0 throughout.
- Loader write 12'h3FF←16'h1234 with CPU idle → wb_ack 3 edges after wb_req, then CPU read returns 16'h1234.
- cpu_en held continuously while wb_req=1, WB_MAX_WAIT=4 → loader granted on the 5th cycle; cpu_stall=1 for exactly that one cycle; wb_ack follows; wb_wait resets.
- Simultaneous CPU read to bank 0 and loader read to bank 2 in adjacent cycles → each requester receives its own bank's data; no crossover between cpu_rdata and wb_rdata.
